// File: rtl/instr_fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_unit_if: instruction memory read port (word index / word back) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input imem_instr);
  modport slave  (input imem_addr, output imem_instr);
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_unit: PC, instruction memory addressing and IF/ID register.    |
// | Optional macro FETCH_PERF_COUNTERS_EN adds fetch/stall event counters.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned MEM_DEPTH = 30,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          stall,
  input  wire logic          flush,
  input  wire logic          redirect_valid,
  input  wire logic [31:0]   redirect_addr,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [31:0] c_mem_depth   = 32'(MEM_DEPTH);
  localparam logic [31:0] c_reset_pc    = 32'(RESET_PC);
  localparam state_t      c_reset_state = (c_reset_pc >= c_mem_depth) ? S_HALT : S_RUN;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] w_pc_seq;

  assign w_pc_seq = r_pc + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_reset_state;
      r_pc    <= c_reset_pc;
      r_instr <= NOP_WORD;
      r_if_pc <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_if_pc <= w_if_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Priority: redirect > stall > flush > normal fetch; HALT only honours redirect.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_if_pc_nxt = r_if_pc;
    w_valid_nxt = r_valid;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_addr;
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
          w_state_nxt = (redirect_addr >= c_mem_depth) ? S_HALT : S_RUN;
        end else if (stall) begin
          w_state_nxt = S_RUN;
        end else begin
          w_pc_nxt    = w_pc_seq;
          w_if_pc_nxt = r_pc;
          w_instr_nxt = flush ? NOP_WORD : imem.imem_instr;
          w_valid_nxt = !flush;
          w_state_nxt = (w_pc_seq >= c_mem_depth) ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        w_instr_nxt = NOP_WORD;
        w_valid_nxt = 1'b0;
        if (redirect_valid) begin
          w_pc_nxt    = redirect_addr;
          w_state_nxt = (redirect_addr < c_mem_depth) ? S_RUN : S_HALT;
        end
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  assign imem.imem_addr = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_if_pc;
  assign if_id_valid    = r_valid;
  assign halted         = (r_state == S_HALT);

`ifdef FETCH_PERF_COUNTERS_EN
  logic        w_fetch_evt, w_stall_evt;
  logic [31:0] r_fetch_count, r_stall_count;

  assign w_fetch_evt = (r_state == S_RUN) && !redirect_valid && !stall && !flush;
  assign w_stall_evt = (r_state == S_RUN) && !redirect_valid && stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_fetch_evt && (r_fetch_count != 32'hFFFFFFFF))
        r_fetch_count <= r_fetch_count + 32'd1;
      if (w_stall_evt && (r_stall_count != 32'hFFFFFFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire
